// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine front panel: program codes,
// panel state encoding and 7-segment patterns (bit order gfedcba).
package wm_pkg;

  typedef enum logic [2:0] {
    ProgColdWash   = 3'b000,
    ProgHotWash    = 3'b001,
    ProgRinsingDry = 3'b010,
    ProgOnlyDry    = 3'b011
  } prog_e;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StLaunch,
    StRunning,
    StDone
  } panel_state_e;

  localparam logic [6:0] SegBlank = 7'h00;
  localparam logic [6:0] SegDash  = 7'h40;
  localparam logic [6:0] SegZero  = 7'h3f;

  // Index 0 is the rightmost entry.
  localparam logic [9:0][6:0] SegDigit = {
    7'h6f, 7'h7f, 7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
  };

endpackage

// File: rtl/wm_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a
// single-cycle pulse on the rising edge of the accepted level.
module wm_debounce #(
  parameter int unsigned Cycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(Cycles + 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d, prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample matching the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(Cycles - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign press_o = level_q & ~prev_q;

endmodule

// File: rtl/wm_panel.sv
// Front-panel controller: program selection, start handshake with the
// washer FSM, and registered two-digit display plus status LEDs.
module wm_panel
  import wm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT     = 16,
  parameter int unsigned NUM_PROGRAMS    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_select,
  input  logic       btn_start,
  input  logic       btn_cancel,
  input  logic       doorclosed,
  input  logic       lockDoor,
  input  logic       program_done,
  input  logic [7:0] timer_display,
  output logic [2:0] program_selection,
  output logic       start,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       led_run,
  output logic       led_done,
  output logic       led_err,
  output logic       led_door
);

  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);

  logic sel_press, start_press, cancel_press, any_press;

  wm_debounce #(.Cycles(DEBOUNCE_CYCLES)) u_db_select (
    .clk_i(clk), .rst_ni(rst), .btn_i(btn_select), .press_o(sel_press)
  );
  wm_debounce #(.Cycles(DEBOUNCE_CYCLES)) u_db_start (
    .clk_i(clk), .rst_ni(rst), .btn_i(btn_start), .press_o(start_press)
  );
  wm_debounce #(.Cycles(DEBOUNCE_CYCLES)) u_db_cancel (
    .clk_i(clk), .rst_ni(rst), .btn_i(btn_cancel), .press_o(cancel_press)
  );

  assign any_press = sel_press | start_press | cancel_press;

  panel_state_e    state_q, state_d;
  logic [2:0]      prog_q, prog_d;
  logic [AckW-1:0] ack_q, ack_d;
  logic            seen_q, seen_d, err_q, err_d, door_q;
  logic [6:0]      tens_q, tens_d, ones_q, ones_d;
  logic [3:0]      tens_val, ones_val;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    return (d > 4'd9) ? SegBlank : SegDigit[d];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      prog_q  <= ProgColdWash;
      ack_q   <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      door_q  <= 1'b0;
      tens_q  <= SegBlank;
      ones_q  <= SegZero;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      ack_q   <= ack_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      door_q  <= doorclosed;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    ack_d   = ack_q;
    seen_d  = seen_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_press) begin
          state_d = StArmed;
          err_d   = 1'b0;
        end else if (sel_press) begin
          prog_d = (prog_q == 3'(NUM_PROGRAMS - 1)) ? 3'd0 : prog_q + 3'd1;
        end
      end
      StArmed: begin
        if (cancel_press) state_d = StIdle;
        else if (doorclosed) state_d = StLaunch;
      end
      StLaunch: begin
        ack_d   = '0;
        seen_d  = 1'b0;
        state_d = StRunning;
      end
      StRunning: begin
        if (!seen_q) begin
          if (lockDoor) begin
            seen_d = 1'b1;
          end else if (ack_q == AckW'(ACK_TIMEOUT - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else begin
            ack_d = ack_q + AckW'(1);
          end
        end else if (program_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (any_press || (door_q && !doorclosed)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign tens_val = 4'(timer_display / 8'd10);
  assign ones_val = 4'(timer_display % 8'd10);

  always_comb begin
    tens_d = SegBlank;
    ones_d = seg_digit({1'b0, prog_q});
    unique case (state_q)
      StRunning: begin
        if (timer_display <= 8'd99) begin
          tens_d = seg_digit(tens_val);
          ones_d = seg_digit(ones_val);
        end else begin
          tens_d = SegDash;
          ones_d = SegDash;
        end
      end
      StDone: begin
        tens_d = SegZero;
        ones_d = SegZero;
      end
      default: ;
    endcase
  end

  assign program_selection = prog_q;
  assign start             = (state_q == StLaunch);
  assign seg_tens          = tens_q;
  assign seg_ones          = ones_q;
  assign led_run           = (state_q == StRunning);
  assign led_done          = (state_q == StDone);
  assign led_err           = err_q;
  assign led_door          = (state_q == StArmed) && !doorclosed;

endmodule

// File: doc/wm_panel.md
# wm_panel

Front-panel controller for the washing-machine controller (FSMW). It debounces the user buttons, sequences program selection, and issues the single-cycle `start` request into FSMW's command inputs. It also consumes FSMW's status outputs (`lockDoor`, `program_done`, `timer_display`) to drive a two-digit 7-segment display and status LEDs. It is the user-facing end of FSMW's `program_selection`/`start`/status interface.

## Interface
- `DEBOUNCE_CYCLES`, 4: cycles a synchronized button level must stay stable before it is accepted.
- `ACK_TIMEOUT`, 16: cycles allowed after `start` for FSMW to assert `lockDoor`.
- `NUM_PROGRAMS`, 4: programs 0..NUM_PROGRAMS-1 (000 COLD_WASH, 001 HOT_WASH, 010 RINSING_DRY, 011 ONLY_DRY).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `btn_select`, `btn_start`, `btn_cancel` in 1 each: raw asynchronous buttons, active-high.
- `doorclosed` in 1: door sensor.
- `lockDoor` in 1: FSMW door lock, meaning a program is running.
- `program_done` in 1: FSMW completion flag.
- `timer_display` in 8: FSMW remaining time, binary.
- `program_selection` out 3: to FSMW.
- `start` out 1: one-cycle start pulse to FSMW.
- `seg_tens`, `seg_ones` out 7: display digits, active-high, bit order gfedcba.
- `led_run`, `led_done`, `led_err`, `led_door` out 1 each: status LEDs.

## Operation
Button path:
- Each button goes through a 2-flop synchronizer, then the debouncer.
- A press event is a single-cycle pulse on the rising edge of the debounced level.

States: IDLE, ARMED, LAUNCH, RUNNING, DONE.
- **IDLE**
  - select press: `program_selection` increments, wrapping NUM_PROGRAMS-1 → 0.
  - start press: go to ARMED.
  - select and start press in the same cycle: start wins; selection unchanged.
- **ARMED**
  - cancel press: go to IDLE. Cancel has priority over a door close in the same cycle.
  - `doorclosed`=1: go to LAUNCH.
  - `led_door`=1 while the door is open.
- **LAUNCH**
  - `start`=1 for exactly this cycle, then go to RUNNING.
  - Ack counter is cleared.
- **RUNNING**
  - Ack counter counts until `lockDoor` is first seen.
  - Counter reaching ACK_TIMEOUT with no `lockDoor` seen: go to IDLE and set `led_err`.
  - After `lockDoor` is seen, `program_done`=1: go to DONE.
  - All buttons are ignored.
  - `led_run`=1.
- **DONE**
  - `led_done`=1.
  - Any press event, or `doorclosed` falling to 0: go to IDLE.

Other rules:
- `led_err` clears on the next start press.
- `program_selection` is held constant in every state except IDLE.

Display:
- IDLE and ARMED: `seg_tens` blank (0), `seg_ones` shows the program number.
- RUNNING: BCD of `timer_display` when ≤ 99. Values above 99 show a dash (7'b1000000) on both digits.
- DONE: "00".

## Timing
Reset values:
- `program_selection`=000, `start`=0.
- All LEDs 0.
- `seg_tens`=0, `seg_ones`=digit "0" (7'b0111111).
- State IDLE; debouncer counters and levels 0.

Latencies:
- Raw button edge to press event: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 edge cycle.
- Any bounce restarts the debounce count.
- ARMED with `doorclosed`=1 at edge N: LAUNCH from N+1, `start` high during cycle N+1, low at N+2.

Reset mid-operation:
- Reset asserted during RUNNING forces IDLE immediately.
- `start` is never re-asserted without a fresh start press.

Display is a registered output, one cycle behind `timer_display`.

## Structure
- Shared package `wm_pkg`: program codes, panel state enum, 7-segment digit/blank/dash constants.
- One sub-module, `wm_debounce` (synchronizer, stability counter, rising-edge pulse), instantiated three times.
- BCD conversion and segment encoding are local combinational logic.

## Test plan
- Reset, then three select presses → `program_selection` 000→001→010→011, `seg_ones` shows 3. A fourth press → 000.
- Start press with `doorclosed`=0 → ARMED, `led_door`=1, `start` stays 0. Raise door → exactly one `start` cycle.
- After launch, drive `lockDoor`=1 and `timer_display`=57 → `seg_tens`="5", `seg_ones`="7". `timer_display`=150 → dashes. `program_done`=1 → `led_done`=1.
- Keep `lockDoor`=0 for 16 cycles after `start` → IDLE with `led_err`=1.
- Bounce `btn_start` toggling every 2 cycles for 20 cycles → no press event. Hold 6+ cycles → one event.
- Select and start pressed in the same cycle in IDLE → ARMED, selection unchanged. Pull `rst` low during RUNNING → all outputs at reset values asynchronously.
